alu_cmd_ctrl: RTL and testbench

Command sequencer for the shared ALU. Accepts a byte stream from the RX deserializer and parses ALU command frames. It latches operands and function, pulses the ALU enable, captures the 16-bit result, and returns it as two bytes (LSB first) to the TX serializer. It sits between the RX/TX byte interfaces and the ALU. It also drives the ALU clock-gate enable so the ALU clock runs only while an operation is in flight.

---
 rtl/alu_ctrl_pkg.sv | 31 +++
 rtl/alu_cmd_ctrl_if.sv | 32 +++
 rtl/alu_ctrl_tx.sv | 105 ++++++++++
 rtl/alu_cmd_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_ctrl_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int FUN_W_DEF       = 4;
  localparam int RES_W           = 16;
  localparam int TIMEOUT_CYC_DEF = 15;

  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_A     = 3'd1,
    RX_B     = 3'd2,
    RX_FUN   = 3'd3,
    ALU_REQ  = 3'd4,
    ALU_WAIT = 3'd5,
    TX_LO    = 3'd6,
    TX_HI    = 3'd7
  } ctrl_state_e;

  typedef enum logic [2:0] {
    TXS_IDLE    = 3'd0,
    TXS_LO_WAIT = 3'd1,
    TXS_LO_HOLD = 3'd2,
    TXS_HI_WAIT = 3'd3,
    TXS_HI_HOLD = 3'd4
  } tx_state_e;

endpackage

// File: rtl/alu_cmd_ctrl_if.sv
// Byte-stream, ALU and serializer signals of the ALU command sequencer.
interface alu_cmd_ctrl_if #(
  parameter int DATA_W = alu_ctrl_pkg::DATA_W_DEF,
  parameter int FUN_W  = alu_ctrl_pkg::FUN_W_DEF
);
  import alu_ctrl_pkg::*;

  logic [DATA_W-1:0] RX_P_DATA;
  logic              RX_D_VLD;
  logic [RES_W-1:0]  ALU_OUT;
  logic              OUT_VALID;
  logic              TX_BUSY;
  logic              ALU_EN;
  logic [FUN_W-1:0]  ALU_FUN;
  logic [DATA_W-1:0] OP_A;
  logic [DATA_W-1:0] OP_B;
  logic              CLK_GATE_EN;
  logic [DATA_W-1:0] TX_P_DATA;
  logic              TX_D_VLD;
  logic              CMD_ERR;

  modport slave (
    input  RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
    output ALU_EN, ALU_FUN, OP_A, OP_B, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

  modport master (
    output RX_P_DATA, RX_D_VLD, ALU_OUT, OUT_VALID, TX_BUSY,
    input  ALU_EN, ALU_FUN, OP_A, OP_B, CLK_GATE_EN, TX_P_DATA, TX_D_VLD, CMD_ERR
  );

endinterface

// File: rtl/alu_ctrl_tx.sv
// Two-byte transmit handshake: sends a captured 16-bit result LSB first over a
// level-based TX_BUSY handshake and flags acceptance of each byte.
module alu_ctrl_tx (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] word,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  output logic        lo_accept,
  output logic        done
);
  import alu_ctrl_pkg::*;

  tx_state_e        state_q, state_d;
  logic [RES_W-1:0] result_q, result_d;
  logic [7:0]       data_q, data_d;
  logic             vld_q, vld_d;

  // Request is raised once the serializer is free and dropped after it samples busy.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    data_d    = data_q;
    vld_d     = vld_q;
    lo_accept = 1'b0;
    done      = 1'b0;
    case (state_q)
      TXS_IDLE: begin
        if (start) begin
          result_d = word;
          if (!tx_busy) begin
            vld_d   = 1'b1;
            data_d  = word[7:0];
            state_d = TXS_LO_HOLD;
          end else begin
            state_d = TXS_LO_WAIT;
          end
        end else begin
          state_d = TXS_IDLE;
        end
      end
      TXS_LO_WAIT: begin
        if (!tx_busy) begin
          vld_d   = 1'b1;
          data_d  = result_q[7:0];
          state_d = TXS_LO_HOLD;
        end else begin
          state_d = TXS_LO_WAIT;
        end
      end
      TXS_LO_HOLD: begin
        if (tx_busy) begin
          vld_d     = 1'b0;
          lo_accept = 1'b1;
          state_d   = TXS_HI_WAIT;
        end else begin
          state_d = TXS_LO_HOLD;
        end
      end
      TXS_HI_WAIT: begin
        if (!tx_busy) begin
          vld_d   = 1'b1;
          data_d  = result_q[15:8];
          state_d = TXS_HI_HOLD;
        end else begin
          state_d = TXS_HI_WAIT;
        end
      end
      TXS_HI_HOLD: begin
        if (tx_busy) begin
          vld_d   = 1'b0;
          done    = 1'b1;
          state_d = TXS_IDLE;
        end else begin
          state_d = TXS_HI_HOLD;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = TXS_IDLE;
      end
    endcase
  end

  // Transmit state, result word and registered serializer outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= TXS_IDLE;
      result_q <= '0;
      data_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
    end
  end

  assign tx_data = data_q;
  assign tx_vld  = vld_q;

endmodule

// File: rtl/alu_cmd_ctrl.sv
// ALU command sequencer: parses CC/DD frames, runs the ALU, returns the result.
// Optional ALU wait timeout is enabled with the ALU_TIMEOUT_EN macro.
module alu_cmd_ctrl #(
  parameter int DATA_W = alu_ctrl_pkg::DATA_W_DEF,
  parameter int FUN_W  = alu_ctrl_pkg::FUN_W_DEF
`ifdef ALU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = alu_ctrl_pkg::TIMEOUT_CYC_DEF
`endif
) (
  input logic           CLK,
  input logic           RST,
  alu_cmd_ctrl_if.slave bus
);
  import alu_ctrl_pkg::*;

  ctrl_state_e       state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [FUN_W-1:0]  alu_fun_q, alu_fun_d;
  logic              alu_en_q, alu_en_d;
  logic              gate_q, gate_d;
  logic              cmd_err_q, cmd_err_d;
  logic              tx_start;
  logic              tx_lo_accept;
  logic              tx_done;

`ifdef ALU_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Frame parser and ALU sequencing; bytes outside IDLE..RX_FUN are ignored.
  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    alu_fun_d = alu_fun_q;
    alu_en_d  = 1'b0;
    cmd_err_d = 1'b0;
    tx_start  = 1'b0;
`ifdef ALU_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          if (bus.RX_P_DATA == CMD_ALU_OP) begin
            state_d = RX_A;
          end else if (bus.RX_P_DATA == CMD_ALU_NOP) begin
            state_d = RX_FUN;
          end else begin
            cmd_err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RX_A: begin
        if (bus.RX_D_VLD) begin
          op_a_d  = bus.RX_P_DATA;
          state_d = RX_B;
        end else begin
          state_d = RX_A;
        end
      end
      RX_B: begin
        if (bus.RX_D_VLD) begin
          op_b_d  = bus.RX_P_DATA;
          state_d = RX_FUN;
        end else begin
          state_d = RX_B;
        end
      end
      RX_FUN: begin
        if (bus.RX_D_VLD) begin
          alu_fun_d = bus.RX_P_DATA[FUN_W-1:0];
          alu_en_d  = 1'b1;
          state_d   = ALU_REQ;
        end else begin
          state_d = RX_FUN;
        end
      end
      ALU_REQ: begin
        state_d = ALU_WAIT;
`ifdef ALU_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ALU_WAIT: begin
        // The result word goes straight into the transmitter on the capture edge.
        if (bus.OUT_VALID) begin
          tx_start = 1'b1;
          state_d  = TX_LO;
        end
`ifdef ALU_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`else
        else begin
          state_d = ALU_WAIT;
        end
`endif
      end
      TX_LO: begin
        if (tx_lo_accept) begin
          state_d = TX_HI;
        end else begin
          state_d = TX_LO;
        end
      end
      TX_HI: begin
        if (tx_done) begin
          state_d = IDLE;
        end else begin
          state_d = TX_HI;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    gate_d = (state_d == ALU_REQ) || (state_d == ALU_WAIT);
  end

  // Control state and registered ALU-side outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      alu_fun_q <= '0;
      alu_en_q  <= 1'b0;
      gate_q    <= 1'b0;
      cmd_err_q <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q  <= alu_en_d;
      gate_q    <= gate_d;
      cmd_err_q <= cmd_err_d;
`ifdef ALU_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  alu_ctrl_tx u_tx (
    .clk       (CLK),
    .rst_n     (RST),
    .start     (tx_start),
    .word      (bus.ALU_OUT),
    .tx_busy   (bus.TX_BUSY),
    .tx_data   (bus.TX_P_DATA),
    .tx_vld    (bus.TX_D_VLD),
    .lo_accept (tx_lo_accept),
    .done      (tx_done)
  );

  assign bus.ALU_EN      = alu_en_q;
  assign bus.ALU_FUN     = alu_fun_q;
  assign bus.OP_A        = op_a_q;
  assign bus.OP_B        = op_b_q;
  assign bus.CLK_GATE_EN = gate_q;
  assign bus.CMD_ERR     = cmd_err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed + randomized bench for alu_cmd_ctrl with a frame-level reference model.
module tb_alu_cmd_ctrl;

  localparam logic [7:0] C_OP  = 8'hCC;
  localparam logic [7:0] C_NOP = 8'hDD;
  localparam int         TMO   = 15;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_cmd_ctrl_if bus ();

  alu_cmd_ctrl dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: retained operands/function and expected pulse totals.
  logic [7:0] exp_a   = 8'h00;
  logic [7:0] exp_b   = 8'h00;
  logic [3:0] exp_fun = 4'h0;
  int         exp_err = 0;
  int         exp_en  = 0;
  int         err_cnt = 0;
  int         en_cnt  = 0;

  always @(posedge CLK) begin
    if (bus.CMD_ERR === 1'b1) err_cnt <= err_cnt + 1;
    if (bus.ALU_EN === 1'b1) en_cnt <= en_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no end expected end of test");
    $fatal(1, "bench timed out");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.RX_P_DATA = b;
    bus.RX_D_VLD  = 1'b1;
    step();
    bus.RX_D_VLD  = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_en"}, bus.ALU_EN, 0);
    chk({tag, "_alu_fun"}, bus.ALU_FUN, 0);
    chk({tag, "_op_a"}, bus.OP_A, 0);
    chk({tag, "_op_b"}, bus.OP_B, 0);
    chk({tag, "_gate"}, bus.CLK_GATE_EN, 0);
    chk({tag, "_tx_data"}, bus.TX_P_DATA, 0);
    chk({tag, "_tx_vld"}, bus.TX_D_VLD, 0);
    chk({tag, "_cmd_err"}, bus.CMD_ERR, 0);
  endtask

  // Plays the serializer for one byte: optional busy period, then accept.
  task automatic recv_byte(input logic [7:0] exp, input int pre);
    int hold;
    for (int i = 0; i < pre; i++) begin
      chk("tx_vld_while_busy", bus.TX_D_VLD, 0);
      step();
    end
    bus.TX_BUSY = 1'b0;
    for (int i = 0; i < 20 && bus.TX_D_VLD !== 1'b1; i++) step();
    chk("tx_vld", bus.TX_D_VLD, 1);
    chk("tx_data", bus.TX_P_DATA, exp);
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) begin
      bus.RX_P_DATA = 8'($urandom);
      bus.RX_D_VLD  = 1'b1;
      step();
      bus.RX_D_VLD  = 1'b0;
      chk("tx_vld_hold", bus.TX_D_VLD, 1);
      chk("tx_data_hold", bus.TX_P_DATA, exp);
    end
    bus.TX_BUSY = 1'b1;
    step();
    chk("tx_vld_drop", bus.TX_D_VLD, 0);
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      step();
      chk("tx_vld_busy_tail", bus.TX_D_VLD, 0);
    end
    bus.TX_BUSY = 1'b0;
  endtask

  task automatic run_frame(input bit is_op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] fb, input logic [15:0] res, input int busy_pre);
    if (is_op) begin
      send_byte(C_OP);
      chk("no_err_on_cc", bus.CMD_ERR, 0);
      send_byte(a);
      send_byte(b);
      exp_a = a;
      exp_b = b;
    end else begin
      send_byte(C_NOP);
      chk("no_err_on_dd", bus.CMD_ERR, 0);
    end
    send_byte(fb);
    exp_fun = fb[3:0];
    exp_en++;
    chk("alu_en_pulse", bus.ALU_EN, 1);
    chk("op_a", bus.OP_A, exp_a);
    chk("op_b", bus.OP_B, exp_b);
    chk("alu_fun", bus.ALU_FUN, exp_fun);
    chk("gate_req", bus.CLK_GATE_EN, 1);
    step();
    chk("alu_en_single", bus.ALU_EN, 0);
    chk("gate_wait", bus.CLK_GATE_EN, 1);
    bus.OUT_VALID = 1'b1;
    bus.ALU_OUT   = res;
    bus.TX_BUSY   = (busy_pre > 0);
    step();
    bus.OUT_VALID = 1'b0;
    bus.ALU_OUT   = 16'($urandom);
    chk("gate_off", bus.CLK_GATE_EN, 0);
    chk("tx_vld_first", bus.TX_D_VLD, (busy_pre == 0) ? 1 : 0);
    recv_byte(res[7:0], busy_pre);
    recv_byte(res[15:8], 0);
    step();
    chk("err_total", err_cnt, exp_err);
    chk("en_total", en_cnt, exp_en);
  endtask

  task automatic junk(input logic [7:0] b);
    bus.OUT_VALID = 1'b1;
    bus.ALU_OUT   = 16'($urandom);
    send_byte(b);
    bus.OUT_VALID = 1'b0;
    exp_err++;
    chk("junk_cmd_err", bus.CMD_ERR, 1);
    chk("junk_no_alu_en", bus.ALU_EN, 0);
    chk("junk_no_tx", bus.TX_D_VLD, 0);
    step();
    chk("junk_err_single", bus.CMD_ERR, 0);
    chk("junk_no_tx_later", bus.TX_D_VLD, 0);
  endtask

  initial begin
    logic [7:0]  jb;
    logic [15:0] r;
    int          kind;
    bus.RX_P_DATA = 8'h00;
    bus.RX_D_VLD  = 1'b0;
    bus.ALU_OUT   = 16'h0000;
    bus.OUT_VALID = 1'b0;
    bus.TX_BUSY   = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    RST = 1'b1;
    step();
    chk_all_zero("post_reset");

    run_frame(1'b1, 8'h12, 8'h34, 8'h00, 16'h0046, 0);
    run_frame(1'b0, 8'h00, 8'h00, 8'h01, 16'hABCD, 0);
    junk(8'h55);
    run_frame(1'b1, 8'h12, 8'h34, 8'h00, 16'h0046, 10);

    // Reset in RX_B abandons the frame and clears retained operands.
    send_byte(C_OP);
    send_byte(8'h77);
    #2 RST = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    exp_a = 8'h00; exp_b = 8'h00; exp_fun = 4'h0;
    step();
    step();
    RST = 1'b1;
    step();
    chk_all_zero("after_release");
    run_frame(1'b0, 8'h00, 8'h00, 8'hF5, 16'h1357, 0);
    run_frame(1'b1, 8'hA5, 8'h5A, 8'h3C, 16'hBEEF, 0);

    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 2);
      r    = 16'($urandom);
      if (kind == 2) begin
        jb = 8'($urandom);
        if (jb == C_OP || jb == C_NOP) jb = jb + 8'd1;
        junk(jb);
      end else begin
        run_frame(kind == 0, 8'($urandom), 8'($urandom), 8'($urandom), r,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
      end
    end

`ifdef ALU_TIMEOUT_EN
    send_byte(C_OP);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    exp_a = 8'h01; exp_b = 8'h02; exp_fun = 4'h3; exp_en++;
    chk("tmo_alu_en", bus.ALU_EN, 1);
    for (int k = 0; k < TMO; k++) begin
      step();
      chk("tmo_gate_on", bus.CLK_GATE_EN, 1);
      chk("tmo_no_err_yet", bus.CMD_ERR, 0);
      chk("tmo_no_tx", bus.TX_D_VLD, 0);
    end
    step();
    exp_err++;
    chk("tmo_cmd_err", bus.CMD_ERR, 1);
    chk("tmo_gate_off", bus.CLK_GATE_EN, 0);
    chk("tmo_no_tx_end", bus.TX_D_VLD, 0);
    step();
    chk("tmo_err_single", bus.CMD_ERR, 0);
    run_frame(1'b1, 8'h21, 8'h43, 8'h02, 16'h6502, 0);
`endif

    step();
    chk("final_err_total", err_cnt, exp_err);
    chk("final_en_total", en_cnt, exp_en);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
